// File: rtl/pixel_frame_capture.sv
// pixel_frame_capture
// Sink end of the convolution pixel stream. Writes one pixel per valid cycle
// into an on-chip frame buffer in bottom-left to top-right scan order (last
// row first, columns left to right). The first SKIP_PIXELS valid pixels of a
// frame are pipeline fill and are dropped. A registered random-access read
// port serves the stored frame in every state.
//
// Optional feature: define CAPTURE_CHECKSUM_EN to add a 16-bit running sum of
// all stored pixels on the checksum output.

module pixel_frame_capture #(
  parameter  int WORD_SIZE    = 8,
  parameter  int ROW_SIZE     = 540,
  parameter  int IMAGE_HEIGHT = 360,
  parameter  int SKIP_PIXELS  = 0,
  localparam int RW           = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1,
  localparam int CW           = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pix_valid,
  input  logic [WORD_SIZE-1:0] pix_in,
  input  logic                 rd_en,
  input  logic [RW-1:0]        rd_row,
  input  logic [CW-1:0]        rd_col,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overflow
`ifdef CAPTURE_CHECKSUM_EN
  ,
  output logic [15:0]          checksum
`endif
);

  localparam int DEPTH = ROW_SIZE * IMAGE_HEIGHT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW    = (SKIP_PIXELS > 0) ? $clog2(SKIP_PIXELS + 1) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(ROW_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SKIP    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [RW-1:0]        row;
  logic [CW-1:0]        col;
  logic [SW-1:0]        skip_cnt;
  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic          idle_like;
  logic          start_acc;
  logic          skip_last;
  logic          wr_en;
  logic          frame_last;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          rd_in_range;

  // Decode of the current cycle: accepted start, skip completion, write strobe
  // and the two buffer addresses.
  // NOTE: every signal assigned in always_comb gets a default first so that
  // no path leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    idle_like   = 1'b0;
    start_acc   = 1'b0;
    skip_last   = 1'b0;
    wr_en       = 1'b0;
    frame_last  = 1'b0;
    wr_addr     = '0;
    rd_addr     = '0;
    rd_in_range = 1'b0;

    idle_like   = (state == S_IDLE) || (state == S_DONE);
    start_acc   = idle_like && start;
    skip_last   = (state == S_SKIP) && pix_valid &&
                  ((int'(skip_cnt) + 1) >= SKIP_PIXELS);
    wr_en       = (state == S_CAPTURE) && pix_valid;
    frame_last  = wr_en && (col == COL_LAST) && (row == '0);
    wr_addr     = AW'(row) * AW'(ROW_SIZE) + AW'(col);
    rd_addr     = AW'(rd_row) * AW'(ROW_SIZE) + AW'(rd_col);
    rd_in_range = (int'(rd_row) < IMAGE_HEIGHT) && (int'(rd_col) < ROW_SIZE);
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start outside IDLE/DONE is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = (SKIP_PIXELS > 0) ? S_SKIP : S_CAPTURE;
      end
      S_SKIP: begin
        if (skip_last) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (frame_last) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    busy = (state == S_SKIP) || (state == S_CAPTURE);
  end

  // Scan position and skip counter; only valid pixels advance them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row      <= ROW_LAST;
      col      <= '0;
      skip_cnt <= '0;
    end else if (start_acc) begin
      row      <= ROW_LAST;
      col      <= '0;
      skip_cnt <= '0;
    end else begin
      if ((state == S_SKIP) && pix_valid) skip_cnt <= skip_cnt + 1'b1;
      if (wr_en) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == '0) ? ROW_LAST : row - 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Completion pulse and sticky overflow for pixels arriving while unarmed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= frame_last;
      if (start_acc)                  overflow <= 1'b0;
      else if (idle_like && pix_valid) overflow <= 1'b1;
    end
  end

  // Frame buffer write port.
  // NOTE: the buffer has no reset; it maps onto block RAM and its contents
  // are only meaningful after a frame has been written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= pix_in;
  end

  // Registered read port; a same-address write in this cycle is not yet
  // visible, so the old contents are returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

`ifdef CAPTURE_CHECKSUM_EN
  // Running 16-bit sum of stored pixels, restarted with each accepted frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            checksum <= '0;
    else if (start_acc) checksum <= '0;
    else if (wr_en)     checksum <= checksum + 16'(pix_in);
  end
`endif

endmodule
